// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings and sizes for the sequential right shifter
package shift_pkg;

    localparam int WIDTH_C = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_step.sv
// rtl/shift_right_step.sv - one combinational right-shift step by s positions with a given fill bit
module shift_right_step #(
    parameter int WIDTH = 32,
    parameter int SW    = 4
) (
    input  logic [WIDTH-1:0] work,
    input  logic             fill,
    input  logic [SW-1:0]    s,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] fill_mask;

    // Ones in the top s positions mark where the fill bit lands.
    assign fill_mask = ~({WIDTH{1'b1}} >> s);
    assign shifted   = (work >> s) | (fill ? fill_mask : '0);

endmodule

// File: rtl/shift_right_seq_32.sv
// rtl/shift_right_seq_32.sv - iterative 32-bit logical/arithmetic right shifter with start/done handshake
module shift_right_seq_32
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    localparam int SW = 4;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] rem;
    logic               fill;
    logic [SW-1:0]      s;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   shifted;

    // Clamping to the remaining count keeps the last step short instead of underflowing.
    always_comb begin
        s        = (rem < SHAMT_W'(STEP)) ? rem[SW-1:0] : SW'(STEP);
        rem_next = rem - SHAMT_W'(s);
    end

    shift_right_step #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_step (
        .work    (work),
        .fill    (fill),
        .s       (s),
        .shifted (shifted)
    );

    assign ready_o = (state == IDLE);
    assign busy_o  = (state == SHIFT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            work   <= '0;
            rem    <= '0;
            fill   <= 1'b0;
            data_o <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        work  <= data_i;
                        rem   <= shamt_i;
                        fill  <= arith_i & data_i[WIDTH-1];
                        state <= (shamt_i != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The result register only changes here, so partial shifts never leak out.
                    data_o <= work;
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
